// File: rtl/npc_lsu_pkg.sv
// Package: npc_lsu_pkg
// Shared definitions for the load/store memory controller:
//   - RISC-V funct3 encodings for access size and signedness
//   - controller FSM state encoding
//   - size_mask(): byte-lane mask for an access of a given funct3, before
//     it is shifted to the byte offset inside the data word
package npc_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Byte mask of an access, right-justified. Signed and unsigned variants
    // share a size, so funct3[2] does not change the mask.
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            3'b000, 3'b100: return 8'h01;
            3'b001, 3'b101: return 8'h03;
            3'b010, 3'b110: return 8'h0F;
            default:        return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Module: lsu_load_align
// Combinational load data alignment and extension. The raw memory word is
// shifted right so the addressed byte sits at bit 0, then sign- or
// zero-extended according to funct3.
// Ports:
//   raw     in   DATA_W  aligned memory word as read from memory
//   off     in   OFF_W   byte offset of the access inside the word
//   funct3  in   3       RISC-V load funct3 (size/sign)
//   data    out  DATA_W  extended load result (0 for unknown funct3)
module lsu_load_align
    import npc_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    // NOTE: every variable written here gets a value before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        shifted = raw >> {off, 3'b000};
        data    = '0;
        // A sized cast of a signed operand sign-extends; of an unsigned one,
        // zero-extends. This avoids zero-width replications when DATA_W=32.
        case (funct3)
            F3_LB:   data = DATA_W'($signed(shifted[7:0]));
            F3_LBU:  data = DATA_W'(shifted[7:0]);
            F3_LH:   data = DATA_W'($signed(shifted[15:0]));
            F3_LHU:  data = DATA_W'(shifted[15:0]);
            F3_LW:   data = DATA_W'($signed(shifted[31:0]));
            F3_LWU:  data = DATA_W'(shifted[31:0]);
            F3_LD:   data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Module: lsu_mem_ctrl
// Load/store memory controller between the EXU (request) and WBU (response).
// Accepts one access per handshake, waits LATENCY cycles, performs the
// memory access, and returns aligned/extended load data or an error flag
// for misaligned accesses and illegal funct3 values.
//
// The memory access is issued on the mem_* port group, which carries what
// the pmem_read / pmem_write calls carry: mem_valid is high for exactly the
// one WAIT cycle with cnt==0 of a legal access, and the memory must commit a
// write (mem_wen=1) on that clock edge and present mem_rdata for a read
// during that same cycle.
//
// Parameters: ADDR_W address width, DATA_W 32 or 64 (64 enables ld/lwu/sd),
//             LATENCY 1..15 cycles from acceptance to resp_valid.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_wen             1 = store, 0 = load
//   req_funct3          RISC-V funct3 (size/sign)
//   req_addr            byte address
//   req_wdata           store data, right-justified
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data; 0 for stores and errors
//   resp_err            misaligned or illegal funct3; no access was made
//   mem_valid           memory access strobe
//   mem_wen             1 = write, 0 = read
//   mem_addr            word-aligned address
//   mem_wdata           store data replicated across byte lanes
//   mem_wmask           byte-lane write enables
//   mem_rdata           read data for mem_addr, valid while mem_valid=1
module lsu_mem_ctrl
    import npc_lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_valid,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int         NB       = DATA_W / 8;
    localparam int         OFF_W    = $clog2(NB);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state, state_next;
    logic [3:0]        cnt;
    logic              cap_wen;
    logic [2:0]        cap_funct3;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic [OFF_W-1:0]  off;
    logic              illegal;
    logic              misaligned;
    logic              acc_err;
    logic              fire;
    logic [DATA_W-1:0] load_data;

    assign off  = cap_addr[OFF_W-1:0];
    assign fire = (state == S_WAIT) && (cnt == 4'd0);

    // Access legality of the captured request.
    always_comb begin
        if (cap_wen) begin
            illegal = cap_funct3[2] || ((cap_funct3[1:0] == 2'b11) && (DATA_W != 64));
        end else begin
            illegal = (cap_funct3 == 3'b111) ||
                      ((DATA_W != 64) && ((cap_funct3 == F3_LWU) || (cap_funct3 == F3_LD)));
        end
        case (cap_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off[1:0] != 2'b00);
            default: misaligned = (off != '0);
        endcase
        acc_err = illegal || misaligned;
    end

    // FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                // Returning to IDLE; the next request is taken a cycle later.
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request capture, latency counter and response registers.
    // NOTE: the captured request is reset too, so a reset mid-transaction
    // leaves nothing behind that a later cycle could act on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            cap_wen    <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_wen    <= req_wen;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        cnt        <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_err   <= acc_err;
                        resp_rdata <= (acc_err || cap_wen) ? '0 : load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    lsu_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .raw    (mem_rdata),
        .off    (off),
        .funct3 (cap_funct3),
        .data   (load_data)
    );

    // Memory side: one strobe per legal access, never in IDLE/RESP.
    assign mem_valid = fire && !acc_err;
    assign mem_wen   = cap_wen;
    assign mem_addr  = cap_addr & ~ADDR_W'(NB - 1);
    assign mem_wmask = NB'(size_mask(cap_funct3)) << off;

    // Store data replicated across lanes so the mask alone selects bytes.
    always_comb begin
        case (cap_funct3[1:0])
            2'b00:   mem_wdata = {NB{cap_wdata[7:0]}};
            2'b01:   mem_wdata = {(NB / 2){cap_wdata[15:0]}};
            2'b10:   mem_wdata = {(NB / 4){cap_wdata[31:0]}};
            default: mem_wdata = cap_wdata;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: unit 0 uses LATENCY=1, unit 1 uses LATENCY=4,
// both DATA_W=32 sharing one word-addressed memory model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_wen    [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        mem_valid  [2];
    logic        mem_wen    [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic [3:0]  mem_wmask  [2];
    logic [31:0] mem_rdata  [2];

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .mem_valid(mem_valid[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]), .mem_rdata(mem_rdata[0])
    );

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .mem_valid(mem_valid[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]), .mem_rdata(mem_rdata[1])
    );

    always #5 clk = ~clk;

    // Memory model and access log.
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    int          wr_cnt [2];
    int          rd_cnt [2];
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    logic [3:0]  last_wr_mask;

    initial begin
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        rd_cnt[0] = 0; rd_cnt[1] = 0;
    end

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        for (int u = 0; u < 2; u++) begin
            if (rst_n === 1'b1 && mem_valid[u] === 1'b1) begin
                if (mem_wen[u]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wmask[u][b]) mem[mem_addr[u][9:2]][b*8 +: 8] <= mem_wdata[u][b*8 +: 8];
                    wr_cnt[u]    <= wr_cnt[u] + 1;
                    last_wr_addr <= mem_addr[u];
                    last_wr_data <= mem_wdata[u];
                    last_wr_mask <= mem_wmask[u];
                end else begin
                    rd_cnt[u] <= rd_cnt[u] + 1;
                end
            end
        end
    end

    // Read data settles mid-cycle, ahead of the edge where the DUT samples it.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mem_rdata[u] = mem[mem_addr[u][9:2]];
    end

    // Scoreboard.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = addr[9:2]; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_access(input int u, input string tag, input logic wen,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_data,
                             input logic exp_err, input int hold);
        exp_t e;
        int   n;
        int   cyc;
        logic saw_ready;
        n = 0;
        while (req_ready[u] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_total++;
        if (req_ready[u] !== 1'b1) begin
            $display("FAIL %s accept: req_ready=%b, required 1", tag, req_ready[u]);
            return;
        end
        n_pass++;
        e.data = exp_data; e.err = exp_err; e.lat = (u == 0) ? 1 : 4;
        sb_q.push_back(e);
        req_wen[u] = wen; req_funct3[u] = f3; req_addr[u] = addr; req_wdata[u] = wdata;
        req_valid[u] = 1'b1;
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        cyc = 0; saw_ready = 1'b0;
        while (resp_valid[u] !== 1'b1 && cyc < 40) begin
            if (req_ready[u] !== 1'b0) saw_ready = 1'b1;
            @(posedge clk); #1; cyc++;
        end
        e = sb_q.pop_front();
        n_total++;
        if (resp_valid[u] !== 1'b1) begin
            $display("FAIL %s resp timeout: resp_valid=%b after %0d cycles, required 1", tag, resp_valid[u], cyc);
            return;
        end
        n_pass++;
        n_total++;
        if (cyc !== e.lat) $display("FAIL %s latency: got %0d, required %0d", tag, cyc, e.lat);
        else n_pass++;
        n_total++;
        if (resp_rdata[u] !== e.data) $display("FAIL %s rdata: got %h, required %h", tag, resp_rdata[u], e.data);
        else n_pass++;
        n_total++;
        if (resp_err[u] !== e.err) $display("FAIL %s err: got %b, required %b", tag, resp_err[u], e.err);
        else n_pass++;
        n_total++;
        if (saw_ready !== 1'b0) $display("FAIL %s busy: req_ready seen %b during wait, required 0", tag, saw_ready);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (resp_valid[u] !== 1'b1 || resp_rdata[u] !== e.data || req_ready[u] !== 1'b0)
                $display("FAIL %s hold %0d: valid=%b rdata=%h ready=%b, required 1 %h 0",
                         tag, i, resp_valid[u], resp_rdata[u], req_ready[u], e.data);
            else n_pass++;
        end
        resp_ready[u] = 1'b1;
        @(posedge clk); #1;
        resp_ready[u] = 1'b0;
        n_total++;
        if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1)
            $display("FAIL %s release: valid=%b ready=%b, required 0 1", tag, resp_valid[u], req_ready[u]);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_wen[u] = 1'b0; req_funct3[u] = 3'b000;
            req_addr[u] = '0; req_wdata[u] = '0; resp_ready[u] = 1'b0;
        end
        #2;
        for (int u = 0; u < 2; u++) begin
            n_total++;
            if (req_ready[u] !== 1'b1 || resp_valid[u] !== 1'b0 || resp_rdata[u] !== 32'h0 || resp_err[u] !== 1'b0)
                $display("FAIL reset u%0d: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                         u, req_ready[u], resp_valid[u], resp_rdata[u], resp_err[u]);
            else n_pass++;
        end
        preload(32'h8000_0000, 32'h80FF_1234);
        preload(32'h8000_0004, 32'hDEAD_BEEF);
        preload(32'h8000_0008, 32'hCAFE_F00D);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word;
        do_access(0, "lw", 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    endtask

    task automatic test_load_extend;
        do_access(0, "lb_neg", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 0);
        do_access(0, "lbu",    1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h0000_0080, 1'b0, 0);
        do_access(0, "lh_neg", 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'hFFFF_80FF, 1'b0, 0);
        do_access(0, "lhu",    1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h0000_80FF, 1'b0, 0);
        do_access(0, "lb_pos", 1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_0012, 1'b0, 0);
    endtask

    task automatic test_store;
        int w0;
        w0 = wr_cnt[0];
        do_access(0, "sb", 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 1'b0, 0);
        n_total++;
        if (wr_cnt[0] - w0 !== 1 || last_wr_addr !== 32'h8000_0000 ||
            last_wr_data !== 32'hABAB_ABAB || last_wr_mask !== 4'b0010)
            $display("FAIL sb write: count=%0d addr=%h data=%h mask=%b, required 1 80000000 abababab 0010",
                     wr_cnt[0] - w0, last_wr_addr, last_wr_data, last_wr_mask);
        else n_pass++;
        do_access(0, "lw_after_sb", 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h80FF_AB34, 1'b0, 0);
        w0 = wr_cnt[0];
        do_access(0, "sh", 1'b1, 3'b001, 32'h8000_0002, 32'h0000_5566, 32'h0, 1'b0, 0);
        n_total++;
        if (wr_cnt[0] - w0 !== 1 || last_wr_addr !== 32'h8000_0000 ||
            last_wr_data !== 32'h5566_5566 || last_wr_mask !== 4'b1100)
            $display("FAIL sh write: count=%0d addr=%h data=%h mask=%b, required 1 80000000 55665566 1100",
                     wr_cnt[0] - w0, last_wr_addr, last_wr_data, last_wr_mask);
        else n_pass++;
        do_access(0, "lw_after_sh", 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h5566_AB34, 1'b0, 0);
    endtask

    task automatic test_errors;
        int w0;
        int r0;
        w0 = wr_cnt[0]; r0 = rd_cnt[0];
        do_access(0, "lw_misaligned", 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 0);
        do_access(0, "sh_misaligned", 1'b1, 3'b001, 32'h8000_0001, 32'h0000_1111, 32'h0, 1'b1, 0);
        do_access(0, "lwu_illegal",   1'b0, 3'b110, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 0);
        do_access(0, "ld_illegal",    1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 0);
        do_access(0, "st_f3_illegal", 1'b1, 3'b110, 32'h8000_0000, 32'h2222_2222, 32'h0, 1'b1, 0);
        do_access(0, "sd_illegal",    1'b1, 3'b011, 32'h8000_0000, 32'h3333_3333, 32'h0, 1'b1, 0);
        n_total++;
        if (wr_cnt[0] !== w0 || rd_cnt[0] !== r0)
            $display("FAIL err_no_access: writes=%0d reads=%0d, required 0 0", wr_cnt[0] - w0, rd_cnt[0] - r0);
        else n_pass++;
    endtask

    task automatic test_latency_hold;
        do_access(1, "lw_lat4_hold", 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    endtask

    task automatic test_back_to_back;
        do_access(1, "b2b_lbu", 1'b0, 3'b100, 32'h8000_0000, 32'h0, 32'h0000_0034, 1'b0, 0);
        do_access(1, "b2b_lh",  1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h0000_5566, 1'b0, 0);
        do_access(1, "b2b_sw",  1'b1, 3'b010, 32'h8000_0004, 32'h0BAD_CAFE, 32'h0, 1'b0, 0);
        do_access(0, "b2b_lw",  1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'h0BAD_CAFE, 1'b0, 0);
    endtask

    task automatic test_reset_mid_wait;
        int w0;
        w0 = wr_cnt[1];
        req_wen[1] = 1'b1; req_funct3[1] = 3'b010;
        req_addr[1] = 32'h8000_0008; req_wdata[1] = 32'h1111_1111;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #3;
        n_total++;
        if (req_ready[1] !== 1'b0)
            $display("FAIL mid_wait busy: req_ready=%b, required 0", req_ready[1]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || resp_rdata[1] !== 32'h0 || resp_err[1] !== 1'b0)
            $display("FAIL async_reset: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                     req_ready[1], resp_valid[1], resp_rdata[1], resp_err[1]);
        else n_pass++;
        repeat (6) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || wr_cnt[1] !== w0)
            $display("FAIL after_reset: ready=%b valid=%b writes=%0d, required 1 0 0",
                     req_ready[1], resp_valid[1], wr_cnt[1] - w0);
        else n_pass++;
        do_access(1, "lw_after_reset", 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_errors();
        test_latency_hold();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
